// File: rtl/dot_product_engine_if.sv
// -----------------------------------------------------------------------------
// dot_product_engine_if
//
// Groups the signals between the dot-product engine and its surroundings:
// the pass control (start/busy), the shared read port of the two operand
// memories, and the valid/ready result handshake.
//
// Modports:
//   master : the dot_product_engine side (drives rd_en/rd_addr, busy, result)
//   slave  : the environment side (memories, start source, result consumer)
//
// Signals:
//   start        start a pass (from the writer's done pulse)
//   busy         engine is not idle
//   rd_en        memory read enable
//   rd_addr      memory read address
//   dout_a       vector A element, valid one cycle after rd_en
//   dout_b       vector B element, same timing as dout_a
//   result       dot product
//   result_valid result is available
//   result_ready downstream accepts result
// -----------------------------------------------------------------------------
interface dot_product_engine_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int VETOR_WIDTH = 4,
   parameter int DEPTH       = VETOR_WIDTH * DATA_WIDTH,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int ACC_WIDTH   = 2 * DATA_WIDTH + ADDR_WIDTH + 1
);
   logic                  start;
   logic                  busy;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] dout_a;
   logic [DATA_WIDTH-1:0] dout_b;
   logic [ACC_WIDTH-1:0]  result;
   logic                  result_valid;
   logic                  result_ready;

   modport master (
      input  start,
      output busy,
      output rd_en,
      output rd_addr,
      input  dout_a,
      input  dout_b,
      output result,
      output result_valid,
      input  result_ready
   );

   modport slave (
      output start,
      input  busy,
      input  rd_en,
      input  rd_addr,
      output dout_a,
      output dout_b,
      input  result,
      input  result_valid,
      output result_ready
   );
endinterface

// File: rtl/dot_product_engine.sv
// -----------------------------------------------------------------------------
// dot_product_engine
//
// On start, reads addresses 0..DEPTH-1 from the shared read port of the two
// operand memories, multiplies each dout_a/dout_b pair and accumulates the
// products. The final sum is offered on a valid/ready handshake.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous, active-low reset
//   bus    dot_product_engine_if.master (start/busy, rd_en/rd_addr,
//          dout_a/dout_b, result/result_valid/result_ready)
//
// Build option:
//   DOT_SIGNED_EN  when defined, operands are two's-complement and products
//                  are sign-extended into the accumulator; otherwise operands
//                  are unsigned and products are zero-extended.
//
// Pipeline: rd_en (cycle n) -> data tag (n+1, aligned with dout_a/b)
//           -> product tag (n+2, aligned with prod_reg) -> accumulate.
// -----------------------------------------------------------------------------
module dot_product_engine #(
   parameter int DATA_WIDTH  = 8,
   parameter int VETOR_WIDTH = 4,
   parameter int DEPTH       = VETOR_WIDTH * DATA_WIDTH,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int ACC_WIDTH   = 2 * DATA_WIDTH + ADDR_WIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dot_product_engine_if.master bus
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;
   localparam int EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                 state_reg;
   logic                   rd_en_reg;
   logic [ADDR_WIDTH-1:0]  rd_addr_reg;
   logic                   busy_reg;
   logic [ACC_WIDTH-1:0]   result_reg;
   logic                   result_valid_reg;
   logic                   data_vld_reg;
   logic                   prod_vld_reg;
   logic [ACC_WIDTH-1:0]   prod_reg;
   logic [ACC_WIDTH-1:0]   acc_reg;
   logic                   drain_cnt_reg;

   logic [PROD_WIDTH-1:0]  prod_full;
   logic [ACC_WIDTH-1:0]   prod_ext;
   logic [ACC_WIDTH-1:0]   acc_next;

`ifdef DOT_SIGNED_EN
   // Widen with sign before multiplying so the low PROD_WIDTH bits are the
   // exact two's-complement product.
   assign prod_full = PROD_WIDTH'($signed(bus.dout_a)) * PROD_WIDTH'($signed(bus.dout_b));
   assign prod_ext  = {{EXT_WIDTH{prod_full[PROD_WIDTH-1]}}, prod_full};
`else
   assign prod_full = PROD_WIDTH'(bus.dout_a) * PROD_WIDTH'(bus.dout_b);
   assign prod_ext  = {{EXT_WIDTH{1'b0}}, prod_full};
`endif

   // Accumulator value after this cycle; also used to latch the result so the
   // final product (accumulated in the last DRAIN cycle) is included.
   assign acc_next = prod_vld_reg ? (acc_reg + prod_reg) : acc_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         rd_en_reg        <= 1'b0;
         rd_addr_reg      <= '0;
         busy_reg         <= 1'b0;
         result_reg       <= '0;
         result_valid_reg <= 1'b0;
         data_vld_reg     <= 1'b0;
         prod_vld_reg     <= 1'b0;
         prod_reg         <= '0;
         acc_reg          <= '0;
         drain_cnt_reg    <= 1'b0;
      end else begin
         // Data/product pipeline advances while a pass is streaming.
         if (state_reg == READ || state_reg == DRAIN) begin
            data_vld_reg <= rd_en_reg;
            prod_vld_reg <= data_vld_reg;
            prod_reg     <= prod_ext;
            acc_reg      <= acc_next;
         end

         case (state_reg)
            IDLE: begin
               acc_reg       <= '0;
               prod_reg      <= '0;
               data_vld_reg  <= 1'b0;
               prod_vld_reg  <= 1'b0;
               rd_addr_reg   <= '0;
               drain_cnt_reg <= 1'b0;
               if (bus.start) begin
                  state_reg <= READ;
                  rd_en_reg <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end

            READ: begin
               if (rd_addr_reg == LAST_ADDR) begin
                  state_reg     <= DRAIN;
                  rd_en_reg     <= 1'b0;
                  drain_cnt_reg <= 1'b0;
               end else begin
                  rd_addr_reg <= rd_addr_reg + 1'b1;
               end
            end

            DRAIN: begin
               // Two cycles: one for the memory read stage, one for the
               // product stage.
               drain_cnt_reg <= 1'b1;
               if (drain_cnt_reg) begin
                  state_reg        <= HOLD;
                  result_reg       <= acc_next;
                  result_valid_reg <= 1'b1;
               end
            end

            HOLD: begin
               if (result_valid_reg && bus.result_ready) begin
                  state_reg        <= IDLE;
                  result_valid_reg <= 1'b0;
                  busy_reg         <= 1'b0;
               end
            end

            default: begin
               state_reg <= IDLE;
               rd_en_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_en        = rd_en_reg;
   assign bus.rd_addr      = rd_addr_reg;
   assign bus.busy         = busy_reg;
   assign bus.result       = result_reg;
   assign bus.result_valid = result_valid_reg;

endmodule

// File: tb/tb_dot_product_engine.sv
// -----------------------------------------------------------------------------
// tb_dot_product_engine
//
// Directed sequence of passes over operand memories filled with ramp,
// maximum, negative-pattern and random data. Expected results come from a
// plain-arithmetic sum of products over the memory contents. Honours
// DOT_SIGNED_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dot_product_engine;

   localparam int DW    = 8;
   localparam int DEPTH = 32;
   localparam int ACCW  = 22;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dot_product_engine_if bus ();

   dot_product_engine dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Operand memories with a registered read port.
   logic [DW-1:0] mem_a [DEPTH];
   logic [DW-1:0] mem_b [DEPTH];

   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.dout_a <= mem_a[bus.rd_addr];
         bus.dout_b <= mem_b[bus.rd_addr];
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: sum of element products, reduced modulo 2^ACCW.
   function automatic logic [ACCW-1:0] model_result();
      int s;
      int ea;
      int eb;
      s = 0;
      for (int k = 0; k < DEPTH; k++) begin
`ifdef DOT_SIGNED_EN
         ea = int'($signed(mem_a[k]));
         eb = int'($signed(mem_b[k]));
`else
         ea = int'(mem_a[k]);
         eb = int'(mem_b[k]);
`endif
         s = s + ea * eb;
      end
      return s[ACCW-1:0];
   endfunction

   // mode 0: ramp a=k,b=1   1: all 255   2: a=0xFF,b=0x02   3: random
   task automatic fill(input int mode);
      for (int k = 0; k < DEPTH; k++) begin
         case (mode)
            0: begin mem_a[k] = k[DW-1:0];                mem_b[k] = 8'd1; end
            1: begin mem_a[k] = 8'hFF;                    mem_b[k] = 8'hFF; end
            2: begin mem_a[k] = 8'hFF;                    mem_b[k] = 8'h02; end
            default: begin
               mem_a[k] = DW'($urandom_range(0, 255));
               mem_b[k] = DW'($urandom_range(0, 255));
            end
         endcase
      end
   endtask

   // Runs one pass starting in the current (idle) cycle. Checks the address
   // stream, result latency and value, and the return to idle.
   task automatic do_pass(input string tag, input bit pulse_read, input bit backpressure);
      logic [ACCW-1:0] exp;
      int n;
      exp = model_result();
      bus.result_ready = !backpressure;
      bus.start = 1'b1;
      tick();                                  // now T1
      bus.start = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin    // cycle T(k+1)
         check({tag, "_rd_en"},   bus.rd_en,   1);
         check({tag, "_rd_addr"}, bus.rd_addr, k);
         check({tag, "_busy"},    bus.busy,    1);
         bus.start = pulse_read && (k == 4);   // pulse in T5
         tick();
      end
      bus.start = 1'b0;
      check({tag, "_drain_rd_en"}, bus.rd_en, 0);
      n = DEPTH + 1;
      while (bus.result_valid !== 1'b1 && n < DEPTH + 12) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, n, DEPTH + 3);
      check({tag, "_result"}, bus.result, exp);
      if (backpressure) begin
         for (int i = 0; i < 10; i++) begin
            check({tag, "_hold_valid"},  bus.result_valid, 1);
            check({tag, "_hold_result"}, bus.result,       exp);
            check({tag, "_hold_busy"},   bus.busy,         1);
            bus.start = (i == 3);              // ignored in HOLD
            tick();
         end
         check({tag, "_pre_hs_valid"}, bus.result_valid, 1);
         bus.result_ready = 1'b1;
         bus.start        = 1'b1;              // ignored in the handshake cycle
         tick();
         bus.result_ready = 1'b0;
         bus.start        = 1'b0;
      end else begin
         tick();
      end
      check({tag, "_idle_valid"},  bus.result_valid, 0);
      check({tag, "_idle_busy"},   bus.busy,         0);
      check({tag, "_idle_rd_en"},  bus.rd_en,        0);
      check({tag, "_kept_result"}, bus.result,       exp);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.start        = 1'b0;
      bus.result_ready = 1'b0;
      fill(0);
      repeat (3) tick();
      check("rst_rd_en",   bus.rd_en,        0);
      check("rst_rd_addr", bus.rd_addr,      0);
      check("rst_busy",    bus.busy,         0);
      check("rst_result",  bus.result,       0);
      check("rst_valid",   bus.result_valid, 0);
      rst_n = 1'b1;
      tick();

      fill(0); do_pass("ramp_start_in_read", 1'b1, 1'b0);
      fill(1); do_pass("max", 1'b0, 1'b0);
      fill(2); do_pass("neg", 1'b0, 1'b0);
      fill(0); do_pass("ramp_backpressure", 1'b0, 1'b1);
      fill(3); do_pass("rand_back_to_back", 1'b0, 1'b0);

      // Reset in the middle of READ.
      fill(3);
      bus.result_ready = 1'b1;
      bus.start = 1'b1;
      tick();                                  // T1
      bus.start = 1'b0;
      repeat (9) tick();                       // T10
      check("mid_read_busy", bus.busy, 1);
      rst_n = 1'b0;
      tick();                                  // T11
      check("mid_rst_rd_en",   bus.rd_en,        0);
      check("mid_rst_rd_addr", bus.rd_addr,      0);
      check("mid_rst_busy",    bus.busy,         0);
      check("mid_rst_result",  bus.result,       0);
      check("mid_rst_valid",   bus.result_valid, 0);
      rst_n = 1'b1;
      tick();
      fill(3); do_pass("after_reset", 1'b0, 1'b0);

      for (int p = 0; p < 4; p++) begin
         fill(3);
         do_pass($sformatf("rand%0d", p), 1'b0, (p == 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation timeout");
   end

endmodule

// File: doc/dot_product_engine.md
# dot_product_engine

Consumer stage for the two-vector operand memories. On `start`, it streams every address from 0 to DEPTH-1 out of the memories' shared read port. It multiplies each `dout_a`/`dout_b` pair and accumulates the products into a single dot-product result. The result is presented on a valid/ready handshake to downstream logic. It sits directly after the memory writer: the writer's `done` pulse is the intended `start` source, and this block drives the writer's `rd_en`/`rd_addr`.

## Interface
- `DATA_WIDTH`, default 8: operand element width.
- `VETOR_WIDTH`, default 4: vector width factor, matches the writer.
- `DEPTH`, default `VETOR_WIDTH*DATA_WIDTH` (32): elements per vector.
- `ADDR_WIDTH`, default `clog2(DEPTH)`: read address width.
- `ACC_WIDTH`, default `2*DATA_WIDTH+ADDR_WIDTH+1` (22): accumulator/result width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `rd_en`  out  1  memory read enable.
- `rd_addr`  out  ADDR_WIDTH  memory read address.
- `dout_a`  in  DATA_WIDTH  vector A element; registered, valid 1 cycle after `rd_en`.
- `dout_b`  in  DATA_WIDTH  vector B element; same timing as `dout_a`.
- `busy`  out  1  high whenever state != IDLE.
- `result`  out  ACC_WIDTH  dot product.
- `result_valid`  out  1  `result` is available.
- `result_ready`  in  1  downstream accepts `result`.

## Operation
- FSM states: IDLE, READ, DRAIN, HOLD.
- **IDLE**
  - `start`=1 moves to READ.
  - Clears the accumulator, product register, product-valid pipeline and address counter.
- **READ**
  - Registered `rd_en`=1, with `rd_addr` stepping 0..DEPTH-1, one address per cycle.
  - After address DEPTH-1 is issued, moves to DRAIN.
- **DRAIN**
  - Exactly 2 cycles with `rd_en`=0 to flush the memory-read and product stages.
  - Then moves to HOLD, with `result` = accumulator and `result_valid`=1.
- **HOLD**
  - `result` and `result_valid` are held stable until `result_valid && result_ready`.
  - On that handshake: `result_valid`→0 and the state returns to IDLE on the next cycle.
  - `result` keeps its value until the next pass completes.
- **Pipeline**
  - A valid tag follows `rd_en` by 1 cycle (data stage) and 2 cycles (product stage).
  - The accumulator adds the product only when the product-stage tag is set.
- **Arithmetic**
  - Products are `2*DATA_WIDTH` bits, extended to ACC_WIDTH.
  - The accumulator wraps modulo 2^ACC_WIDTH; no overflow flag. The default ACC_WIDTH cannot overflow.
- **Ignored inputs**
  - `start` is ignored in READ, DRAIN and HOLD, including in the same cycle as the HOLD handshake.
  - `result_ready` is ignored outside HOLD.
- **Reset**
  - Reset mid-pass aborts immediately to IDLE.
  - Reset values: `rd_en`=0, `rd_addr`=0, `busy`=0, `result`=0, `result_valid`=0; accumulator and pipeline cleared.

## Timing
- `start` is sampled high in cycle T0. Address k is driven with `rd_en`=1 in cycle T(k+1).
- Operand data for address k arrives in T(k+2). Its product is registered for T(k+3) and accumulated at the end of T(k+3).
- DRAIN occupies T(DEPTH+1) and T(DEPTH+2).
- `result_valid` first rises in T(DEPTH+3), i.e. 35 cycles after the start cycle at defaults.
- `busy` is 1 from T1 through the handshake cycle.
- If `result_ready` is already high, the handshake completes in T(DEPTH+3) and IDLE is reached in T(DEPTH+4).
- Minimum start-to-start spacing is DEPTH+4 cycles.
- Throughput: one element per cycle, no bubbles during READ.

## Configuration
- `DOT_SIGNED_EN` defined: `dout_a`/`dout_b` are two's-complement. Products are signed and sign-extended into the accumulator; `result` is signed ACC_WIDTH.
- `DOT_SIGNED_EN` undefined (default): operands unsigned, products zero-extended, `result` unsigned.

## Test plan
- Unsigned ramp (`DOT_SIGNED_EN` undefined), memory model with a[k]=k, b[k]=1, `result_ready`=1:
  - `rd_addr` covers 0..31 on consecutive cycles.
  - `result`=496 with `result_valid` in T35; IDLE in T36.
- Maximum values, a[k]=b[k]=255:
  - `result`=2080800 (0x1FC020); no wrap.
- Signed build (`DOT_SIGNED_EN` defined), a[k]=0xFF (-1), b[k]=0x02:
  - `result`=-64 = 0x3FFFC0 (22-bit).
- Backpressure: hold `result_ready`=0 for 10 cycles after `result_valid`:
  - `result`/`result_valid` stay stable and `busy`=1.
  - Ready pulse → `result_valid`=0 next cycle, and a new `start` is accepted the cycle after.
- `start` pulsed during READ at T5 and during HOLD:
  - Ignored in both cases; single pass with unchanged result 496 (ramp data).
- `rst_n`=0 at T10 mid-READ:
  - Next cycle all outputs are at reset values.
  - A subsequent `start` produces the correct result from a cleared accumulator.
